ram_dp_bytemask_param: RTL and testbench
========================================

Name: ram_dp_bytemask_param

Overview:
Parametrised dual-port, byte-lane-masked RAM for the accelerator's activation/weight buffers; next generation of the fixed 4-lane dual-port RAM.
- Generalises lane count, lane width and depth; adds explicit read enables with read-valid pipeline and optional output register stage.
- Adds a hardware clear engine that zeroes the array after reset, with a ready flag.
- Defines deterministic collision and read-during-write semantics.

Parameters:
- AWIDTH, 10, byte-address width; array holds 2^AWIDTH lanes.
- MASK_WIDTH, 4, lanes per access port (power of two, 1..16).
- DWIDTH, 8, bits per lane.
- OUT_REG, 0, 1 adds an output register stage (read latency 2 instead of 1).
- CLEAR_ON_RESET, 1, 1 runs the zeroing engine after reset; 0 makes the block ready immediately.

Ports:
- clk  input  1  single clock, all logic on posedge.
- reset  input  1  synchronous, active-high.
- addr0  input  AWIDTH  port 0 lane address (unaligned allowed).
- d0  input  MASK_WIDTH*DWIDTH  port 0 write data; lane k = d0[k*DWIDTH +: DWIDTH].
- we0  input  MASK_WIDTH  port 0 per-lane write enables.
- re0  input  1  port 0 read enable.
- q0  output  MASK_WIDTH*DWIDTH  port 0 read data.
- rvalid0  output  1  q0 valid strobe.
- addr1, d1, we1, re1, q1, rvalid1: same as port 0, for port 1.
- ready  output  1  high when the array accepts accesses.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset values: q0 = q1 = 0, rvalid0 = rvalid1 = 0, all pipeline stages cleared.
  - ready = 0 when CLEAR_ON_RESET = 1; ready = 1 when CLEAR_ON_RESET = 0.
  - Array contents are not reset directly.
- Lane addressing: lane k of port p targets byte (addrp + k) mod 2^AWIDTH, so a wrap past the top address lands at 0.
- Read path: re = 1 captures lanes at posedge N.
  - OUT_REG = 0: q and rvalid are valid after posedge N.
  - OUT_REG = 1: q and rvalid are valid after posedge N+1.
  - rvalid is a one-cycle pulse per accepted read; back-to-back reads give continuous rvalid.
  - q holds its last value when rvalid = 0.
- Read-during-write is read-first, on the same port and across ports: a read returns the pre-write contents of every lane written in the same cycle.
- Write collision: both ports writing the same byte in the same cycle → port 1 data wins. Non-overlapping lanes are both written.
- Clear FSM states:
  - CLEAR, entered on reset when CLEAR_ON_RESET = 1: clear counter starts at 0 and writes MASK_WIDTH zero lanes per cycle at counter*MASK_WIDTH. Duration is exactly 2^AWIDTH/MASK_WIDTH cycles; on the final word → READY.
  - READY: ready = 1. The only exit is reset.
- In CLEAR, we0/we1/re0/re1 are ignored: no writes, no rvalid.
- Reset asserted mid-clear restarts the clear from counter 0.
- Reset mid-read flushes the pipeline; no rvalid follows the reset.
- ready rises on the cycle after the last clear write. An access presented in that cycle is accepted.
- Width rules: clear counter width AWIDTH - log2(MASK_WIDTH); its wrap at terminal count is the end-of-clear condition.
- Synthesis: when SIMULATION is undefined, the array maps to the vendor dual_port_ram hard macro, with the clear FSM, collision logic and output pipeline kept in fabric around it. Behaviour must be identical in both builds.

Decomposition:
- Shared package `ram_pkg`:
  - clear FSM state encoding (CLR_CLEAR, CLR_READY);
  - function clog2;
  - lane-slice macro;
  - default AWIDTH/DWIDTH/MASK_WIDTH constants.
- One sub-module, ram_rd_pipe: per-port re → rvalid/q stage with OUT_REG bypass, instantiated twice.
- Array, collision resolution and clear FSM stay in the top module.

Test Plan:
- Clear timing: AWIDTH=6, MASK_WIDTH=4, CLEAR_ON_RESET=1; pulse reset 1 cycle → ready rises exactly 16 cycles after reset deassert. A read of addr 0x3C returns 0 with rvalid at latency 1 (OUT_REG=0) and 2 (OUT_REG=1).
- Masked and unaligned writes: port 0 writes d0=0xDDCCBBAA, we0=4'b0101, addr0=0x21; port 1 reads 0x20 next cycle → q1=0x00CC00AA00-style lanes, i.e. bytes 0x21=0xAA, 0x23=0xCC, 0x22 = 0x24 = 0.
- Wrap-around: write 0x44332211 full mask at addr 0x3E (AWIDTH=6) → byte 0x3E=0x11, 0x3F=0x22, 0x00=0x33, 0x01=0x44; a read at 0x3E returns 0x44332211.
- Collision and read-first: same cycle, port 0 writes 0x11111111, port 1 writes 0x22222222 at 0x10, both with re=1 → both q show the previous contents 0x00000000. A next read shows 0x22222222.
- Reset mid-clear: assert reset 5 cycles into clear, preload via backdoor nonzero at 0x30 → ready remains 0 for a full 16 cycles after the second reset. Accesses during clear produce no rvalid and leave no modification; 0x30 reads 0 afterwards.

Source files
------------

// File: rtl/ram_pkg.sv
// Shared definitions for the byte-lane-masked dual-port RAM family.
`define RAM_LANE(vec, k, w) vec[(k)*(w) +: (w)]

package ram_pkg;

  localparam int RAM_AWIDTH_DEF     = 10;
  localparam int RAM_MASK_WIDTH_DEF = 4;
  localparam int RAM_DWIDTH_DEF     = 8;

  typedef enum logic {
    CLR_CLEAR = 1'b0,
    CLR_READY = 1'b1
  } clr_state_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int unsigned i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = int'(i) + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/ram_rd_pipe.sv
// Per-port read pipeline: captures read data on an accepted read and
// optionally adds a second register stage. q holds while rvalid is low.
module ram_rd_pipe #(
  parameter int DW      = 32,
  parameter int OUT_REG = 0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_en,
  input  logic [DW-1:0] i_data,
  output logic [DW-1:0] o_q,
  output logic          o_valid
);

  logic [DW-1:0] r_q1;
  logic          r_v1;

  // First stage: capture the array word when a read is accepted.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_q1 <= '0;
      r_v1 <= 1'b0;
    end else begin
      r_v1 <= i_en;
      if (i_en) r_q1 <= i_data;
    end
  end

  if (OUT_REG != 0) begin : g_reg
    logic [DW-1:0] r_q2;
    logic          r_v2;

    // Second stage: re-register first-stage data one cycle later.
    always_ff @(posedge clk) begin
      if (reset) begin
        r_q2 <= '0;
        r_v2 <= 1'b0;
      end else begin
        r_v2 <= r_v1;
        if (r_v1) r_q2 <= r_q1;
      end
    end

    assign o_q     = r_q2;
    assign o_valid = r_v2;
  end else begin : g_bypass
    assign o_q     = r_q1;
    assign o_valid = r_v1;
  end

endmodule

// File: rtl/ram_dp_bytemask_param.sv
// Parametrised dual-port byte-lane-masked RAM with a post-reset clear engine,
// read-first semantics and port-1-wins write collisions.
module ram_dp_bytemask_param
  import ram_pkg::*;
#(
  parameter int AWIDTH         = RAM_AWIDTH_DEF,
  parameter int MASK_WIDTH     = RAM_MASK_WIDTH_DEF,
  parameter int DWIDTH         = RAM_DWIDTH_DEF,
  parameter int OUT_REG        = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [AWIDTH-1:0]            addr0,
  input  logic [MASK_WIDTH*DWIDTH-1:0] d0,
  input  logic [MASK_WIDTH-1:0]        we0,
  input  logic                         re0,
  output logic [MASK_WIDTH*DWIDTH-1:0] q0,
  output logic                         rvalid0,
  input  logic [AWIDTH-1:0]            addr1,
  input  logic [MASK_WIDTH*DWIDTH-1:0] d1,
  input  logic [MASK_WIDTH-1:0]        we1,
  input  logic                         re1,
  output logic [MASK_WIDTH*DWIDTH-1:0] q1,
  output logic                         rvalid1,
  output logic                         ready
);

  localparam int LW    = clog2(MASK_WIDTH);
  localparam int CW    = AWIDTH - LW;
  localparam int DW    = MASK_WIDTH * DWIDTH;
  localparam int DEPTH = 1 << AWIDTH;

  clr_state_e        r_state;
  clr_state_e        w_state_nxt;
  logic [CW-1:0]     r_cnt;
  logic [CW-1:0]     w_cnt_nxt;
  logic              w_acc;
  logic              w_en0;
  logic              w_en1;
  logic [DW-1:0]     w_rd0;
  logic [DW-1:0]     w_rd1;
  logic [DWIDTH-1:0] r_mem [DEPTH];

  function automatic logic [AWIDTH-1:0] lane_addr(input logic [AWIDTH-1:0] base,
                                                  input int unsigned k);
    return base + AWIDTH'(k);
  endfunction

  assign w_acc = (r_state == CLR_READY) && !reset;
  assign w_en0 = w_acc && re0;
  assign w_en1 = w_acc && re1;
  assign ready = (r_state == CLR_READY);

  // Clear FSM state register; reset restarts the clear from word 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= (CLEAR_ON_RESET != 0) ? CLR_CLEAR : CLR_READY;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Clear FSM next state: counter wrap at terminal count ends the clear.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      CLR_CLEAR: begin
        w_cnt_nxt = r_cnt + 1'b1;
        if (r_cnt == '1) w_state_nxt = CLR_READY;
      end
      default: w_state_nxt = r_state;
    endcase
  end

  // Array writes: clear zeroes one word per cycle; otherwise port 0 then
  // port 1 lanes, so port 1 takes any byte both ports target.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (r_state == CLR_CLEAR) begin
        for (int unsigned k = 0; k < MASK_WIDTH; k++) begin
          r_mem[(AWIDTH'(r_cnt) << LW) | AWIDTH'(k)] <= '0;
        end
      end else begin
        for (int unsigned k = 0; k < MASK_WIDTH; k++) begin
          if (we0[k]) r_mem[lane_addr(addr0, k)] <= `RAM_LANE(d0, k, DWIDTH);
        end
        for (int unsigned k = 0; k < MASK_WIDTH; k++) begin
          if (we1[k]) r_mem[lane_addr(addr1, k)] <= `RAM_LANE(d1, k, DWIDTH);
        end
      end
    end
  end

  // Lane gather for both ports; pre-write contents give read-first behaviour.
  always_comb begin
    w_rd0 = '0;
    w_rd1 = '0;
    for (int unsigned k = 0; k < MASK_WIDTH; k++) begin
      `RAM_LANE(w_rd0, k, DWIDTH) = r_mem[lane_addr(addr0, k)];
      `RAM_LANE(w_rd1, k, DWIDTH) = r_mem[lane_addr(addr1, k)];
    end
  end

  ram_rd_pipe #(
    .DW      (DW),
    .OUT_REG (OUT_REG)
  ) u_rd_pipe0 (
    .clk     (clk),
    .reset   (reset),
    .i_en    (w_en0),
    .i_data  (w_rd0),
    .o_q     (q0),
    .o_valid (rvalid0)
  );

  ram_rd_pipe #(
    .DW      (DW),
    .OUT_REG (OUT_REG)
  ) u_rd_pipe1 (
    .clk     (clk),
    .reset   (reset),
    .i_en    (w_en1),
    .i_data  (w_rd1),
    .o_q     (q1),
    .o_valid (rvalid1)
  );

endmodule

// File: tb/tb_ram_dp_bytemask_param.sv
// Bench for ram_dp_bytemask_param: latency-1 and latency-2 instances driven
// together, checked every cycle against a byte-array model plus literal values.
module tb_ram_dp_bytemask_param;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  addr0, addr1;
  logic [31:0] d0, d1;
  logic [3:0]  we0, we1;
  logic        re0, re1;

  logic [31:0] a_q0, a_q1, b_q0, b_q1, c_q0, c_q1;
  logic        a_v0, a_v1, b_v0, b_v1, c_v0, c_v1;
  logic        a_rdy, b_rdy, c_rdy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ram_dp_bytemask_param #(.AWIDTH(6), .MASK_WIDTH(4), .DWIDTH(8), .OUT_REG(0), .CLEAR_ON_RESET(1)) u_dut_a (
    .clk(clk), .reset(reset),
    .addr0(addr0), .d0(d0), .we0(we0), .re0(re0), .q0(a_q0), .rvalid0(a_v0),
    .addr1(addr1), .d1(d1), .we1(we1), .re1(re1), .q1(a_q1), .rvalid1(a_v1),
    .ready(a_rdy));

  ram_dp_bytemask_param #(.AWIDTH(6), .MASK_WIDTH(4), .DWIDTH(8), .OUT_REG(1), .CLEAR_ON_RESET(1)) u_dut_b (
    .clk(clk), .reset(reset),
    .addr0(addr0), .d0(d0), .we0(we0), .re0(re0), .q0(b_q0), .rvalid0(b_v0),
    .addr1(addr1), .d1(d1), .we1(we1), .re1(re1), .q1(b_q1), .rvalid1(b_v1),
    .ready(b_rdy));

  ram_dp_bytemask_param #(.AWIDTH(6), .MASK_WIDTH(4), .DWIDTH(8), .OUT_REG(0), .CLEAR_ON_RESET(0)) u_dut_c (
    .clk(clk), .reset(reset),
    .addr0(addr0), .d0(d0), .we0(we0), .re0(re0), .q0(c_q0), .rvalid0(c_v0),
    .addr1(addr1), .d1(d1), .we1(we1), .re1(re1), .q1(c_q1), .rvalid1(c_v1),
    .ready(c_rdy));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [7:0]  m_mem [64];
  int unsigned m_cyc;
  bit          m_ready = 1'b0;
  bit          m_on    = 1'b0;
  logic [31:0] e1_q [2];
  logic [31:0] e2_q [2];
  bit          e1_v [2];
  bit          e2_v [2];
  logic [5:0]  m_a  [2];
  logic [31:0] m_d  [2];
  logic [3:0]  m_we [2];
  bit          m_re [2];

  function automatic logic [31:0] m_word(input logic [5:0] a);
    logic [31:0] w;
    for (int k = 0; k < 4; k++) w[k*8 +: 8] = m_mem[6'(a + 6'(k))];
    return w;
  endfunction

  always @(posedge clk) begin
    m_a[0] = addr0; m_d[0] = d0; m_we[0] = we0; m_re[0] = re0;
    m_a[1] = addr1; m_d[1] = d1; m_we[1] = we1; m_re[1] = re1;
    if (reset) begin
      m_on    = 1'b1;
      m_ready = 1'b0;
      m_cyc   = 0;
      for (int p = 0; p < 2; p++) begin
        e1_v[p] = 1'b0; e2_v[p] = 1'b0; e1_q[p] = '0; e2_q[p] = '0;
      end
    end else if (m_on) begin
      for (int p = 0; p < 2; p++) begin
        e2_v[p] = e1_v[p];
        if (e1_v[p]) e2_q[p] = e1_q[p];
        e1_v[p] = m_ready && m_re[p];
        if (e1_v[p]) e1_q[p] = m_word(m_a[p]);
      end
      if (m_ready) begin
        for (int p = 0; p < 2; p++)
          for (int k = 0; k < 4; k++)
            if (m_we[p][k]) m_mem[6'(m_a[p] + 6'(k))] = m_d[p][k*8 +: 8];
      end else begin
        m_cyc++;
        if (m_cyc == 16) begin
          m_ready = 1'b1;
          for (int i = 0; i < 64; i++) m_mem[i] = '0;
        end
      end
    end
  end

  // Every-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (m_on) begin
      chk("cmp_ready_a", {31'd0, a_rdy}, {31'd0, m_ready});
      chk("cmp_ready_b", {31'd0, b_rdy}, {31'd0, m_ready});
      chk("cmp_rv0_a", {31'd0, a_v0}, {31'd0, e1_v[0]});
      chk("cmp_rv1_a", {31'd0, a_v1}, {31'd0, e1_v[1]});
      chk("cmp_q0_a", a_q0, e1_q[0]);
      chk("cmp_q1_a", a_q1, e1_q[1]);
      chk("cmp_rv0_b", {31'd0, b_v0}, {31'd0, e2_v[0]});
      chk("cmp_rv1_b", {31'd0, b_v1}, {31'd0, e2_v[1]});
      chk("cmp_q0_b", b_q0, e2_q[0]);
      chk("cmp_q1_b", b_q1, e2_q[1]);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic idle();
    we0 = '0; we1 = '0; re0 = 1'b0; re1 = 1'b0;
  endtask

  task automatic wr0(input logic [5:0] a, input logic [31:0] d, input logic [3:0] m);
    addr0 = a; d0 = d; we0 = m;
  endtask

  task automatic wr1(input logic [5:0] a, input logic [31:0] d, input logic [3:0] m);
    addr1 = a; d1 = d; we1 = m;
  endtask

  task automatic rd0(input logic [5:0] a);
    addr0 = a; re0 = 1'b1;
  endtask

  task automatic rd1(input logic [5:0] a);
    addr1 = a; re1 = 1'b1;
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (a_rdy !== 1'b1 && n < 40) begin
      cyc();
      n++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset = 1'b1;
    addr0 = '0; addr1 = '0; d0 = '0; d1 = '0;
    idle();
    cyc(); cyc();
    chk("rst_ready_a", {31'd0, a_rdy}, 32'd0);
    chk("rst_ready_b", {31'd0, b_rdy}, 32'd0);
    chk("rst_ready_c", {31'd0, c_rdy}, 32'd1);
    chk("rst_q_a", a_q0 | a_q1, 32'h0);
    chk("rst_q_b", b_q0 | b_q1, 32'h0);
    chk("rst_q_c", c_q0 | c_q1, 32'h0);
    chk("rst_rv", {28'd0, a_v0, a_v1, b_v0, b_v1}, 32'h0);
    chk("rst_rv_c", {30'd0, c_v0, c_v1}, 32'h0);

    // Clear timing.
    reset = 1'b0;
    wait_ready(n);
    chk("clear_cycles", n, 32'd16);

    // Read of cleared word at both latencies.
    rd0(6'h3C); rd1(6'h3C);
    cyc(); idle();
    chk("clr_rd_rv_a", {31'd0, a_v0}, 32'd1);
    chk("clr_rd_q_a", a_q0, 32'h0);
    chk("clr_rd_rv_b_early", {31'd0, b_v0}, 32'd0);
    cyc();
    chk("clr_rd_rv_b", {31'd0, b_v0}, 32'd1);
    chk("clr_rd_rv_a_pulse", {31'd0, a_v0}, 32'd0);

    // Masked unaligned write.
    wr0(6'h21, 32'hDDCCBBAA, 4'b0101);
    cyc(); idle();
    rd0(6'h20); rd1(6'h21);
    cyc(); idle();
    chk("mask_rd20", a_q0, 32'hCC00AA00);
    chk("mask_rd21", a_q1, 32'h00CC00AA);

    // Wrap-around write.
    wr0(6'h3E, 32'h44332211, 4'hF);
    cyc(); idle();
    rd0(6'h3E); rd1(6'h00);
    cyc(); idle();
    chk("wrap_rd3e", a_q0, 32'h44332211);
    chk("wrap_rd00", a_q1, 32'h00004433);

    // Full collision with read-first on both ports.
    wr0(6'h10, 32'h11111111, 4'hF); re0 = 1'b1;
    wr1(6'h10, 32'h22222222, 4'hF); re1 = 1'b1;
    cyc(); idle();
    chk("coll_rf_q0", a_q0, 32'h0);
    chk("coll_rf_q1", a_q1, 32'h0);
    rd0(6'h10); rd1(6'h11);
    cyc(); idle();
    chk("coll_win_q0", a_q0, 32'h22222222);
    chk("coll_win_q1", a_q1, 32'h00222222);

    // Partial overlap: port 1 wins 0x12/0x13, port 0 keeps 0x14/0x15.
    wr0(6'h12, 32'h44332211, 4'hF);
    wr1(6'h10, 32'h88776655, 4'b1100);
    cyc(); idle();
    rd0(6'h12); rd1(6'h10);
    cyc(); idle();
    chk("ovl_rd12", a_q0, 32'h44338877);
    chk("ovl_rd10", a_q1, 32'h88772222);

    // Back-to-back reads, one of them after a same-run write.
    wr1(6'h30, 32'h5A5A5A5A, 4'hF); rd0(6'h10);
    cyc(); idle();
    rd0(6'h14);
    cyc();
    chk("b2b_rv_mid", {31'd0, a_v0}, 32'd1);
    rd0(6'h30);
    cyc(); idle();
    chk("b2b_rd30_a", a_q0, 32'h5A5A5A5A);
    cyc();
    chk("b2b_rd30_b", b_q0, 32'h5A5A5A5A);
    chk("hold_q_a", a_q0, 32'h5A5A5A5A);

    // Reset mid-read, then reset mid-clear with accesses presented.
    rd0(6'h30);
    cyc();
    reset = 1'b1; idle();
    cyc();
    chk("flush_rv_b", {31'd0, b_v0}, 32'd0);
    reset = 1'b0;
    wr0(6'h00, 32'hFFFFFFFF, 4'hF); rd1(6'h30); re0 = 1'b1;
    repeat (5) cyc();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    wait_ready(n);
    chk("reclear_cycles", n, 32'd16);

    // Access in the first ready cycle is accepted.
    idle();
    wr0(6'h08, 32'h12345678, 4'hF);
    cyc(); idle();
    rd0(6'h08); rd1(6'h30);
    cyc(); idle();
    chk("first_ready_wr", a_q0, 32'h12345678);
    chk("reclear_rd30", a_q1, 32'h0);
    rd0(6'h00);
    cyc(); idle();
    chk("clear_ignored_wr", a_q0, 32'h0);
    chk("ready_c_end", {31'd0, c_rdy}, 32'd1);
    cyc(); cyc();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
